// File: rtl/board_lift_pkg.sv
// Shared types and default geometry for the yellow lift board.
// Also used by the renderer and the pole-status detector.
package board_lift_pkg;

  typedef enum logic [1:0] {
    TOP    = 2'd0,
    DOWN   = 2'd1,
    BOTTOM = 2'd2,
    UP     = 2'd3
  } board_state_t;

  localparam logic [9:0]  BL_Y_TOP    = 10'd210;
  localparam logic [9:0]  BL_Y_BOTTOM = 10'd290;
  localparam int unsigned BL_STEP     = 2;

  // Step down by s, never passing lim; 11-bit sum so nothing wraps.
  function automatic logic [9:0] clamp_add(input logic [9:0] y,
                                           input logic [2:0] s,
                                           input logic [9:0] lim);
    logic [10:0] sum;
    sum = {1'b0, y} + {8'b0, s};
    return (sum >= {1'b0, lim}) ? lim : sum[9:0];
  endfunction

  // Step up by s, never passing lim; compares y against lim+s to avoid underflow.
  function automatic logic [9:0] clamp_sub(input logic [9:0] y,
                                           input logic [2:0] s,
                                           input logic [9:0] lim);
    logic [10:0] floor_v;
    floor_v = {1'b0, lim} + {8'b0, s};
    return ({1'b0, y} <= floor_v) ? lim : (y - {7'b0, s});
  endfunction

endpackage

// File: rtl/board_lift_fsm_frame_tick_gen.sv
// Synchronises the level frame strobe into Clk and emits a one-cycle
// pulse on each rising frame edge.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic fs_meta_q;
  logic fs_q;
  logic fd_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fs_meta_q <= 1'b0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      fs_meta_q <= frame_clk;
      fs_q      <= fs_meta_q;
      fd_q      <= fs_q;
    end
  end

  assign tick = fs_q & ~fd_q;

endmodule

// File: rtl/board_lift_fsm.sv
// Yellow lift board animator: moves the board between its rest positions at
// STEP pixels per frame and reports its position and last displacement.
module board_lift_fsm
  import board_lift_pkg::*;
#(
  parameter logic [9:0]  Y_TOP    = BL_Y_TOP,
  parameter logic [9:0]  Y_BOTTOM = BL_Y_BOTTOM,
  parameter int unsigned STEP     = BL_STEP
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic              board_yellow_down,
  input  logic              obstruct,
  output logic [9:0]        board_y,
  output logic signed [3:0] board_dy,
  output logic              board_moving,
  output logic              board_at_bottom
);

  localparam logic [2:0] STEP_W = 3'(STEP);

  logic              tick;
  board_state_t      state_q, state_d;
  logic [9:0]        y_q, y_d;
  logic signed [3:0] dy_q, dy_d;
  logic [9:0]        y_dn, y_up;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  always_comb begin
    y_dn    = clamp_add(y_q, STEP_W, Y_BOTTOM);
    y_up    = clamp_sub(y_q, STEP_W, Y_TOP);
    state_d = state_q;
    y_d     = y_q;
    dy_d    = dy_q;
    if (tick) begin
      dy_d = '0;
      unique case (state_q)
        TOP:    if (board_yellow_down)  state_d = DOWN;
        BOTTOM: if (!board_yellow_down) state_d = UP;
        // While in motion the sampled target picks the direction, so a
        // reversal takes its first step on the same tick.
        DOWN, UP: begin
          if (board_yellow_down) begin
            if (!obstruct) begin
              y_d  = y_dn;
              dy_d = 4'(y_dn - y_q);
            end
            state_d = (y_d == Y_BOTTOM) ? BOTTOM : DOWN;
          end else begin
            y_d     = y_up;
            dy_d    = 4'(y_up - y_q);
            state_d = (y_up == Y_TOP) ? TOP : UP;
          end
        end
        default: state_d = TOP;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= TOP;
      y_q     <= Y_TOP;
      dy_q    <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      dy_q    <= dy_d;
    end
  end

  assign board_y         = y_q;
  assign board_dy        = dy_q;
  assign board_moving    = (state_q == DOWN) || (state_q == UP);
  assign board_at_bottom = (state_q == BOTTOM);

endmodule

// File: doc/board_lift_fsm.md
# board_lift_fsm

Animates the yellow lift board in response to the lever state produced by the pole-status detector (`board_yellow_down`). It moves the board between a top and a bottom rest position at a fixed rate of pixels per video frame. It publishes the board's y-position for the sprite/collision stages. It also publishes the per-frame displacement so the character logic can carry a player standing on the board.

## Interface
- `Y_TOP`, default 10'd210: board y at rest, up position; requires `Y_TOP < Y_BOTTOM`.
- `Y_BOTTOM`, default 10'd290: board y at rest, down position.
- `STEP`, default 2: pixels moved per frame tick; legal range 1..7.
- `Clk`, input, 1: system clock; the only clock.
- `Reset`, input, 1: synchronous, active-low reset.
- `frame_clk`, input, 1: VGA vsync-rate frame strobe (level, not pulse).
- `board_yellow_down`, input, 1: lever target; 1 = board should be down, 0 = up.
- `obstruct`, input, 1: a character is directly beneath the board; blocks downward motion only.
- `board_y`, output, 10: current board top-edge y.
- `board_dy`, output, 4 signed: displacement applied at the most recent frame tick.
- `board_moving`, output, 1: high in `DOWN`/`UP` states.
- `board_at_bottom`, output, 1: high in state `BOTTOM`.

## Operation
- Frame tick:
  - `frame_clk` passes through a 2-flop synchroniser (`fs`), then a delay flop (`fd`).
  - `tick = fs & ~fd`, which is one `Clk` cycle per rising frame edge.
  - All state, `board_y` and `board_dy` updates occur only on the edge where `tick`=1.
- State encoding: `TOP`, `DOWN`, `BOTTOM`, `UP`. `board_yellow_down` and `obstruct` are sampled on the tick edge.
- `TOP`:
  - target=1 → `DOWN`; y unchanged; dy=0.
  - Otherwise the board stays; dy=0.
- `DOWN`:
  - target=0 → `UP`, and the upward step is applied this tick (see `UP`).
  - Else if obstruct=1 → stay, dy=0.
  - Else y ← min(y+STEP, Y_BOTTOM) and dy = applied delta.
  - If the new y equals Y_BOTTOM → `BOTTOM`.
- `BOTTOM`:
  - target=0 → `UP`; y unchanged; dy=0.
  - Otherwise the board stays; dy=0.
- `UP`:
  - target=1 → `DOWN`, and a downward step is applied this tick (obstruct rule applies).
  - Else y ← max(y−STEP, Y_TOP) and dy = −applied delta.
  - If the new y equals Y_TOP → `TOP`. `obstruct` is ignored in this state.
- Arithmetic:
  - Clamp comparisons use 11-bit intermediates; there is no wrap-around.
  - If the travel distance is not a multiple of STEP, the last step is shorter.
  - `board_dy` is always in −7..+7.
- `board_dy` holds its value between ticks and reflects only the last tick.
- Outputs `board_moving` and `board_at_bottom` are decoded combinationally from the state register.

## Timing
- Reset values (Reset=0 at a `Clk` edge):
  - State `TOP`, `board_y`=Y_TOP, `board_dy`=0.
  - Synchroniser/delay flops = 0, so `board_moving`=0 and `board_at_bottom`=0.
- Reset mid-motion returns the board to Y_TOP on the next edge with no intermediate positions.
- Latency:
  - A `frame_clk` rising edge produces `tick` 2–3 `Clk` cycles later.
  - Outputs change on that tick edge and are visible the following cycle.
- A target change between ticks has no effect until the next tick; glitches shorter than a frame are ignored.
- Simultaneous events:
  - Target reversal wins over obstruct when the direction becomes `UP`.
  - Reaching the endpoint and a reversed target on the same tick: the endpoint state is entered, and the reversal is acted on at the next tick.
- Travel time with default parameters: (290−210)/2 = 40 ticks.

## Structure
- `board_lift_pkg` holds:
  - `board_state_t` enum (`TOP`, `DOWN`, `BOTTOM`, `UP`).
  - Default `Y_TOP`/`Y_BOTTOM`/`STEP` constants, shared with the renderer and the pole-status detector.
- Sub-module `frame_tick_gen`: synchroniser plus rising-edge pulse; ports `Clk`, `Reset`, `frame_clk`, `tick`.
- The top-level consists of the state register, the y/dy registers and the next-state logic.

## Test plan
- Reset:
  - Hold Reset=0 for 3 cycles with frame_clk toggling → board_y=210, dy=0, moving=0, at_bottom=0.
  - Reset mid-descent at y=250 → y=210 on the next edge.
- Full descent, defaults:
  - target=1, obstruct=0 → `DOWN` at tick 1.
  - y = 212, 214, …, 290 over ticks 2–41; dy=+2 each tick.
  - `BOTTOM` at tick 41; dy=0 from tick 42.
- Uneven step, STEP=3:
  - Descent takes 26 steps of +3 (y=288), then one step of +2 → y=290.
  - Never exceeds 290.
- Obstruct:
  - At y=240 in `DOWN`, hold obstruct=1 for 5 ticks → y stays 240, dy=0, moving=1.
  - Release obstruct → y=242.
- Reversal: at y=250 in `DOWN`, drop target to 0 → same tick y=248, dy=−2, state `UP`. Ascent ends at 210.
- Tick gating:
  - Toggle target several times within one frame, ending at 0, while in `TOP` → no motion.
  - frame_clk held high for 1000 cycles → exactly one tick.
